seg7_capture: RTL and testbench
===============================

SEG7_CAPTURE -- requirements
Module: seg7_capture

Interface
REQ-001 Parameter STABLE_CYCLES, default 4: consecutive identical synchronized samples required to accept a segment pattern; legal range 2..15.
REQ-002 clk  input  1  clock; all logic on the rising edge.
REQ-003 reset  input  1  reset, synchronous, active-high.
REQ-004 seg_in  input  7  asynchronous segment bus, active-high, bit0=a ... bit6=g (uo_out[6:0] of the animation driver).
REQ-005 out_ready  input  1  consumer accepts the current event when high with out_valid.
REQ-006 clear_overrun  input  1  synchronous clear of the sticky overrun flag.
REQ-007 out_valid  output  1  an event is held on the out_* bus.
REQ-008 out_pattern  output  7  accepted raw segment pattern.
REQ-009 out_code  output  4  hex value decoded from out_pattern; 0 when out_known=0.
REQ-010 out_known  output  1  out_pattern matches an entry of the hex table.
REQ-011 out_interval  output  24  clock cycles since the previous accepted event, saturating at 24'hFFFFFF.
REQ-012 overrun  output  1  sticky; an event was dropped because the holding register was full.

Function
REQ-013 seg_in SHALL pass through a two-flop synchronizer (s1, s2) before any other use.
REQ-014 Glitch filter: candidate register cand, counter cnt (4 bit); s2!=cand -> cand<=s2, cnt<=1; else cnt<=cnt+1, saturating at STABLE_CYCLES.
REQ-015 Accept condition: cnt==STABLE_CYCLES and cand!=acc, where acc is the last accepted pattern; on accept, acc<=cand and one event is generated in that cycle.
REQ-016 Patterns that toggle back before reaching STABLE_CYCLES SHALL generate no event; returning to acc SHALL generate no event.
REQ-017 Latency: seg_in changed and held before rising edge 1 -> out_valid high after edge STABLE_CYCLES+3 (edge 7 at default).
REQ-018 Decode table (pattern->code): 3F->0, 06->1, 5B->2, 4F->3, 66->4, 6D->5, 7D->6, 07->7, 7F->8, 6F->9, 77->A, 7C->B, 39->C, 5E->D, 79->E, 71->F; any other pattern -> out_known=0, out_code=0.
REQ-019 Interval counter ic (24 bit): loads 1 on the accept edge, otherwise increments, saturating at FFFFFF; an event reports the value of ic before that edge.
REQ-020 The first event after reset SHALL report out_interval=0 regardless of ic.
REQ-021 Holding register: an event loads out_* and sets out_valid when out_valid=0 or (out_valid and out_ready) in the same cycle.
REQ-022 out_valid and out_ready both high with no new event -> out_valid<=0 on that edge.
REQ-023 Event while out_valid=1 and out_ready=0 -> event dropped, held data unchanged, overrun<=1; acc and ic still update.
REQ-024 out_* SHALL remain stable while out_valid=1 and out_ready=0.
REQ-025 overrun clears only via clear_overrun or reset; a same-cycle drop and clear_overrun leave overrun=1.

Reset
REQ-026 Reset SHALL clear s1, s2, cand and acc to 7'h00, cnt to 0, ic to 0, the first-event flag to 1, and out_valid, out_pattern, out_code, out_known, out_interval and overrun to 0.
REQ-027 Blank bus (00) after reset SHALL generate no event; reset mid-filter or mid-hold SHALL discard all pending state with no event emitted.

Verification
REQ-028 Reset, out_ready=1, seg_in=3F held -> out_valid high exactly after edge 7, out_code=0, out_known=1, out_interval=0.
REQ-029 Accepted 06, then seg_in=5B applied 1000 cycles after the 06 change -> second event out_code=2, out_interval=1000.
REQ-030 seg_in pulses 7F for 2 cycles then returns to the accepted 3F -> no event, out_valid stays 0.
REQ-031 seg_in=49 (unmapped) -> event with out_pattern=49, out_known=0, out_code=0.
REQ-032 out_ready=0, accept 3F then 06 -> out_pattern remains 3F, overrun=1; pulse clear_overrun -> overrun=0.
REQ-033 Hold 3F for 2^24+10 cycles, then apply 06 -> out_interval=FFFFFF; assert reset during the filter window of a later change -> no event, all outputs 0.

Source files
------------

// File: rtl/seg7_capture.sv
// Captures the settled seven-segment pattern of an animation driver, decodes it to
// a hex digit and reports each new pattern with the cycle interval since the previous one.
module seg7_capture #(
   parameter int unsigned STABLE_CYCLES = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [6:0]  seg_in,
   input  logic        out_ready,
   input  logic        clear_overrun,
   output logic        out_valid,
   output logic [6:0]  out_pattern,
   output logic [3:0]  out_code,
   output logic        out_known,
   output logic [23:0] out_interval,
   output logic        overrun
);

   localparam logic [3:0] STABLE = 4'(STABLE_CYCLES);

   logic [6:0]  s1, s2, cand, acc;
   logic [3:0]  cnt;
   logic [23:0] ic;
   logic        first_evt;
   logic        accept, load, drop;
   logic [3:0]  dec_code;
   logic        dec_known;

   assign accept = (cnt == STABLE) && (cand != acc);
   assign load   = accept && (!out_valid || out_ready);
   assign drop   = accept && out_valid && !out_ready;

   always_comb begin
      dec_known = 1'b1;
      dec_code  = '0;
      case (cand)
         7'h3F: dec_code = 4'h0;
         7'h06: dec_code = 4'h1;
         7'h5B: dec_code = 4'h2;
         7'h4F: dec_code = 4'h3;
         7'h66: dec_code = 4'h4;
         7'h6D: dec_code = 4'h5;
         7'h7D: dec_code = 4'h6;
         7'h07: dec_code = 4'h7;
         7'h7F: dec_code = 4'h8;
         7'h6F: dec_code = 4'h9;
         7'h77: dec_code = 4'hA;
         7'h7C: dec_code = 4'hB;
         7'h39: dec_code = 4'hC;
         7'h5E: dec_code = 4'hD;
         7'h79: dec_code = 4'hE;
         7'h71: dec_code = 4'hF;
         default: begin
            dec_known = 1'b0;
            dec_code  = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         s1           <= '0;
         s2           <= '0;
         cand         <= '0;
         acc          <= '0;
         cnt          <= '0;
         ic           <= '0;
         first_evt    <= 1'b1;
         out_valid    <= 1'b0;
         out_pattern  <= '0;
         out_code     <= '0;
         out_known    <= 1'b0;
         out_interval <= '0;
         overrun      <= 1'b0;
      end else begin
         s1 <= seg_in;
         s2 <= s1;

         if (s2 != cand) begin
            cand <= s2;
            cnt  <= 4'd1;
         end else if (cnt != STABLE) begin
            cnt <= cnt + 4'd1;
         end

         // acc and ic advance on every accept, even when the event itself is dropped
         if (accept) begin
            acc       <= cand;
            ic        <= 24'd1;
            first_evt <= 1'b0;
         end else if (ic != '1) begin
            ic <= ic + 24'd1;
         end

         if (load) begin
            out_valid    <= 1'b1;
            out_pattern  <= cand;
            out_code     <= dec_code;
            out_known    <= dec_known;
            out_interval <= first_evt ? '0 : ic;
         end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end

         if (drop) begin
            overrun <= 1'b1;
         end else if (clear_overrun) begin
            overrun <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_seg7_capture.sv
// Scoreboard bench for seg7_capture: a cycle-accurate model predicts each event's
// pattern, decode, interval and output edge; a monitor pops and compares on handshake.
module tb_seg7_capture;

   localparam int unsigned SC = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [6:0]  seg_in = '0;
   logic        out_ready = 1'b0;
   logic        clear_overrun = 1'b0;
   logic        out_valid;
   logic [6:0]  out_pattern;
   logic [3:0]  out_code;
   logic        out_known;
   logic [23:0] out_interval;
   logic        overrun;

   seg7_capture #(.STABLE_CYCLES(SC)) dut (
      .clk           (clk),
      .reset         (reset),
      .seg_in        (seg_in),
      .out_ready     (out_ready),
      .clear_overrun (clear_overrun),
      .out_valid     (out_valid),
      .out_pattern   (out_pattern),
      .out_code      (out_code),
      .out_known     (out_known),
      .out_interval  (out_interval),
      .overrun       (overrun)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [6:0]  pat;
      logic [3:0]  code;
      logic        known;
      logic [23:0] iv;
      int unsigned edge_n;
   } ev_t;

   ev_t         sbq[$];
   ev_t         me;
   int          n_cmp = 0;
   int          n_bad = 0;
   bit          mon_en = 1'b0;
   bit          first_ev = 1'b1;
   int unsigned last_acc = 0;
   logic [6:0]  cur_acc = '0;

   logic [6:0] hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
   logic [6:0] seq [17] = '{7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F,
                            7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71, 7'h3F, 7'h49};

   task automatic decode(input logic [6:0] p, output logic [3:0] c, output logic k);
      c = '0;
      k = 1'b0;
      for (int i = 0; i < 16; i++)
         if (hex_tab[i] == p) begin
            c = 4'(i);
            k = 1'b1;
         end
   endtask

   // Drive p on a falling edge and keep it for 'hold' cycles; a change is accepted
   // on rising edge cyc+SC+3 counted from the drive point.
   task automatic apply(input logic [6:0] p, input int unsigned hold, input bit push, input bit sat);
      ev_t         e;
      int unsigned a;
      @(negedge clk);
      seg_in = p;
      a = cyc + SC + 3;
      if (p != cur_acc) begin
         e.pat = p;
         decode(p, e.code, e.known);
         e.edge_n = a;
         if (first_ev) e.iv = '0;
         else if (sat || (a - last_acc) > 32'h00FF_FFFF) e.iv = 24'hFF_FFFF;
         else e.iv = 24'(a - last_acc);
         first_ev = 1'b0;
         last_acc = a;
         cur_acc  = p;
         if (push) sbq.push_back(e);
      end
      repeat (hold - 1) @(negedge clk);
   endtask

   task automatic model_reset();
      sbq.delete();
      first_ev = 1'b1;
      cur_acc  = '0;
   endtask

   task automatic wait_drain(input string name);
      for (int i = 0; i < 200 && sbq.size() != 0; i++) @(negedge clk);
      n_cmp++;
      if (sbq.size() != 0) begin
         n_bad++;
         $display("FAIL %s_drain: %0d events still expected, required 0", name, sbq.size());
         sbq.delete();
      end
   endtask

   always begin
      @(negedge clk);
      #1;
      if (mon_en && out_valid && out_ready) begin
         n_cmp++;
         if (sbq.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_event: got pattern %h at edge %0d, required no event", out_pattern, cyc);
         end else begin
            me = sbq.pop_front();
            if (out_pattern !== me.pat || out_code !== me.code || out_known !== me.known ||
                out_interval !== me.iv || cyc != me.edge_n) begin
               n_bad++;
               $display("FAIL event: got pat=%h code=%h known=%b iv=%h edge=%0d, required pat=%h code=%h known=%b iv=%h edge=%0d",
                        out_pattern, out_code, out_known, out_interval, cyc,
                        me.pat, me.code, me.known, me.iv, me.edge_n);
            end
         end
      end
   end

   task automatic test_reset();
      reset = 1'b1;
      seg_in = 7'h3F;
      out_ready = 1'b1;
      repeat (3) @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b, required 0", out_valid); end
      n_cmp++;
      if (out_pattern !== 7'h00 || out_code !== 4'h0 || out_known !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_data: got pat=%h code=%h known=%b, required 00/0/0", out_pattern, out_code, out_known);
      end
      n_cmp++;
      if (out_interval !== 24'h0 || overrun !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_iv_ovr: got iv=%h ovr=%b, required 0/0", out_interval, overrun);
      end
      seg_in = '0;
   endtask

   task automatic test_first_event();
      @(negedge clk);
      reset = 1'b0;
      model_reset();
      mon_en = 1'b1;
      repeat (10) @(negedge clk);
      apply(7'h3F, 12, 1'b1, 1'b0);
      wait_drain("first_event");
   endtask

   task automatic test_decode();
      for (int i = 0; i < 17; i++)
         apply(seq[i], SC + 2 + $urandom_range(0, 9), 1'b1, 1'b0);
      repeat (8) @(negedge clk);
      wait_drain("decode");
   endtask

   task automatic test_interval();
      apply(7'h06, 1000, 1'b1, 1'b0);
      apply(7'h5B, 12, 1'b1, 1'b0);
      wait_drain("interval");
   endtask

   task automatic test_glitch();
      int unsigned lens [2] = '{2, SC - 1};
      bit saw;
      for (int k = 0; k < 2; k++) begin
         saw = 1'b0;
         @(negedge clk);
         seg_in = 7'h7F;
         for (int unsigned j = 1; j < lens[k]; j++) begin
            @(negedge clk);
            saw |= out_valid;
         end
         @(negedge clk);
         seg_in = cur_acc;
         repeat (15) begin
            @(negedge clk);
            saw |= out_valid;
         end
         n_cmp++;
         if (saw !== 1'b0) begin
            n_bad++;
            $display("FAIL glitch_len%0d: got out_valid=1, required 0", lens[k]);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [6:0] b2b [6] = '{7'h66, 7'h7D, 7'h07, 7'h7F, 7'h77, 7'h39};
      for (int i = 0; i < 6; i++)
         apply(b2b[i], (i == 5) ? 12 : SC, 1'b1, 1'b0);
      wait_drain("back_to_back");
   endtask

   task automatic test_backpressure();
      mon_en = 1'b0;
      @(negedge clk);
      out_ready = 1'b0;
      apply(7'h3F, 12, 1'b0, 1'b0);
      n_cmp++;
      if (out_valid !== 1'b1 || out_pattern !== 7'h3F || out_code !== 4'h0 || out_known !== 1'b1 || overrun !== 1'b0) begin
         n_bad++;
         $display("FAIL bp_hold: got v=%b pat=%h code=%h known=%b ovr=%b, required 1/3F/0/1/0",
                  out_valid, out_pattern, out_code, out_known, overrun);
      end
      apply(7'h06, 12, 1'b0, 1'b0);
      n_cmp++;
      if (out_valid !== 1'b1 || out_pattern !== 7'h3F || out_code !== 4'h0 || overrun !== 1'b1) begin
         n_bad++;
         $display("FAIL bp_drop: got v=%b pat=%h code=%h ovr=%b, required 1/3F/0/1",
                  out_valid, out_pattern, out_code, overrun);
      end
      apply(7'h4F, 1, 1'b0, 1'b0);
      for (int i = 0; i < 50 && cyc != last_acc - 1; i++) @(negedge clk);
      clear_overrun = 1'b1;
      @(negedge clk);
      clear_overrun = 1'b0;
      n_cmp++;
      if (overrun !== 1'b1 || out_pattern !== 7'h3F) begin
         n_bad++;
         $display("FAIL bp_drop_vs_clear: got ovr=%b pat=%h, required 1/3F", overrun, out_pattern);
      end
      repeat (4) @(negedge clk);
      clear_overrun = 1'b1;
      @(negedge clk);
      clear_overrun = 1'b0;
      n_cmp++;
      if (overrun !== 1'b0 || out_valid !== 1'b1) begin
         n_bad++;
         $display("FAIL bp_clear: got ovr=%b v=%b, required 0/1", overrun, out_valid);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      n_cmp++;
      if (out_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL bp_release: got out_valid=%b, required 0", out_valid);
      end
      @(negedge clk);
      out_ready = 1'b1;
      mon_en = 1'b1;
      apply(7'h6D, 12, 1'b1, 1'b0);
      wait_drain("bp_after");
   endtask

   task automatic test_saturation();
      apply(7'h3F, 12, 1'b1, 1'b0);
      wait_drain("sat_pre");
      @(negedge clk);
      force dut.ic = 24'hFF_FFFD;
      @(negedge clk);
      release dut.ic;
      repeat (20) @(negedge clk);
      apply(7'h06, 12, 1'b1, 1'b1);
      wait_drain("saturation");
   endtask

   task automatic test_reset_mid();
      bit saw;
      @(negedge clk);
      seg_in = 7'h7D;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      seg_in = '0;
      model_reset();
      repeat (2) @(negedge clk);
      n_cmp++;
      if ({out_valid, out_pattern, out_code, out_known, out_interval, overrun} !== '0) begin
         n_bad++;
         $display("FAIL reset_filter: got v=%b pat=%h code=%h known=%b iv=%h ovr=%b, required all 0",
                  out_valid, out_pattern, out_code, out_known, out_interval, overrun);
      end
      reset = 1'b0;
      saw = 1'b0;
      repeat (15) begin
         @(negedge clk);
         saw |= out_valid;
      end
      n_cmp++;
      if (saw !== 1'b0) begin n_bad++; $display("FAIL reset_filter_noevent: got out_valid=1, required 0"); end

      out_ready = 1'b0;
      mon_en = 1'b0;
      apply(7'h3F, 12, 1'b0, 1'b0);
      apply(7'h06, 12, 1'b0, 1'b0);
      n_cmp++;
      if (out_valid !== 1'b1 || out_interval !== 24'h0 || overrun !== 1'b1) begin
         n_bad++;
         $display("FAIL reset_hold_pre: got v=%b iv=%h ovr=%b, required 1/0/1", out_valid, out_interval, overrun);
      end
      @(negedge clk);
      reset = 1'b1;
      seg_in = '0;
      model_reset();
      @(negedge clk);
      reset = 1'b0;
      n_cmp++;
      if ({out_valid, out_pattern, out_code, out_known, out_interval, overrun} !== '0) begin
         n_bad++;
         $display("FAIL reset_hold: got v=%b pat=%h code=%h known=%b iv=%h ovr=%b, required all 0",
                  out_valid, out_pattern, out_code, out_known, out_interval, overrun);
      end
      out_ready = 1'b1;
      mon_en = 1'b1;
      repeat (15) @(negedge clk);
      apply(7'h5B, 12, 1'b1, 1'b0);
      wait_drain("reset_after");
   endtask

   initial begin
      test_reset();
      test_first_event();
      test_decode();
      test_interval();
      test_glitch();
      test_back_to_back();
      test_backpressure();
      test_saturation();
      test_reset_mid();
      repeat (4) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
